// File: rtl/common_pkg.sv
// Shared pipeline types for the 5-stage core: EX control word, hazard
// controller state and the grouped stall/bubble/flush vector.
package common_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] write_back_id;
        logic       mem_read;
        logic       reg_write;
    } control_t;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hazard_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic bubble_ex;
        logic bubble_wb;
        logic flush_id;
    } stall_vec_t;

    // x0 is hardwired to zero, so a load targeting it can never feed a consumer.
    function automatic logic load_use_hit(
        input control_t   ex,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2
    );
        return ex.mem_read && ex.reg_write && (ex.write_back_id != REG_ZERO) &&
               ((use1 && (rs1 == ex.write_back_id)) ||
                (use2 && (rs2 == ex.write_back_id)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline side is the
// master, the controller is the slave.
interface hazard_ctrl_if #(
    parameter int unsigned PERF_W = 32
);
    import common_pkg::*;

    control_t          control_ex;
    logic [4:0]        rs_1_id;
    logic [4:0]        rs_2_id;
    logic              uses_rs1_id;
    logic              uses_rs2_id;
    logic              mdu_op_ex;
    logic              mdu_done;
    logic              dmem_req_mem;
    logic              dmem_ready;
    logic              branch_taken_ex;

    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              bubble_ex;
    logic              bubble_wb;
    logic              flush_id;
    logic              mdu_start;
    logic              mdu_abort;
    logic              mdu_err;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output control_ex, rs_1_id, rs_2_id, uses_rs1_id, uses_rs2_id,
               mdu_op_ex, mdu_done, dmem_req_mem, dmem_ready, branch_taken_ex,
        input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
               flush_id, mdu_start, mdu_abort, mdu_err, stall_cycles
    );

    modport slave (
        input  control_ex, rs_1_id, rs_2_id, uses_rs1_id, uses_rs2_id,
               mdu_op_ex, mdu_done, dmem_req_mem, dmem_ready, branch_taken_ex,
        output stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb,
               flush_id, mdu_start, mdu_abort, mdu_err, stall_cycles
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, bubbles and flushes for memory wait,
// multi-cycle MDU ops, taken branches and load-use; MDU watchdog and stall counter.
module hazard_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned PERF_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    import common_pkg::*;

    localparam int unsigned     WD_W    = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

    hazard_state_e   state_q, state_d;
    logic            mdu_err_q, mdu_err_d;
    logic [WD_W-1:0] wd_count;
    logic            wd_inc, wd_clr;
    logic            mem_wait, load_use, mdu_hold, start, abort;
    stall_vec_t      sv;

    assign mem_wait = hz.dmem_req_mem & ~hz.dmem_ready;
    assign load_use = load_use_hit(hz.control_ex, hz.rs_1_id, hz.rs_2_id,
                                   hz.uses_rs1_id, hz.uses_rs2_id);

    always_comb begin
        state_d   = state_q;
        mdu_err_d = mdu_err_q;
        sv        = '0;
        start     = 1'b0;
        abort     = 1'b0;
        mdu_hold  = 1'b0;
        wd_inc    = 1'b0;
        wd_clr    = 1'b0;
        // Everything is gated while reset is held so no pulse leaks out mid-reset.
        if (rst) begin
            if (mem_wait) begin
                sv.stall_if  = 1'b1;
                sv.stall_id  = 1'b1;
                sv.stall_ex  = 1'b1;
                sv.stall_mem = 1'b1;
                sv.bubble_wb = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (hz.mdu_op_ex) begin
                            start    = 1'b1;
                            mdu_hold = 1'b1;
                            wd_clr   = 1'b1;
                            state_d  = MDU_WAIT;
                        end
                    end
                    MDU_WAIT: begin
                        if (hz.mdu_done) begin
                            state_d = RUN;
                        end else if (wd_count == WD_LAST) begin
                            abort     = 1'b1;
                            mdu_err_d = 1'b1;
                            state_d   = RUN;
                        end else begin
                            mdu_hold = 1'b1;
                            wd_inc   = 1'b1;
                        end
                    end
                    default: state_d = RUN;
                endcase

                // A held EX keeps its branch; a taken branch squashes any load-use consumer.
                if (mdu_hold) begin
                    sv.stall_if = 1'b1;
                    sv.stall_id = 1'b1;
                    sv.stall_ex = 1'b1;
                end else if (hz.branch_taken_ex) begin
                    sv.flush_id  = 1'b1;
                    sv.bubble_ex = 1'b1;
                end else if (load_use) begin
                    sv.stall_if  = 1'b1;
                    sv.stall_id  = 1'b1;
                    sv.bubble_ex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            mdu_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mdu_err_q <= mdu_err_d;
        end
    end

    sat_counter #(.W(WD_W)) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .inc   (wd_inc),
        .count (wd_count)
    );

    sat_counter #(.W(PERF_W)) u_stall_perf (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (sv.stall_if),
        .count (hz.stall_cycles)
    );

    assign hz.stall_if  = sv.stall_if;
    assign hz.stall_id  = sv.stall_id;
    assign hz.stall_ex  = sv.stall_ex;
    assign hz.stall_mem = sv.stall_mem;
    assign hz.bubble_ex = sv.bubble_ex;
    assign hz.bubble_wb = sv.bubble_wb;
    assign hz.flush_id  = sv.flush_id;
    assign hz.mdu_start = start;
    assign hz.mdu_abort = abort;
    assign hz.mdu_err   = mdu_err_q;

endmodule
